hilo_div_ctrl: RTL and testbench

Sequencer between the main control unit and the `Div` unit. It accepts a one-cycle DIV request from control, latches the operands, and drives the `div_start`/`dividend`/`divisor` handshake. It waits for `finished` or `div_zero` and commits `remainder`→HI and `quotient`→LO. It also owns the architectural HI/LO registers (MTHI/MTLO writes, MFHI/MFLO reads) and produces the pipeline stall signal.

---
 rtl/hilo_div_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
//   Sits between the main control unit and the iterative Div unit.
//   - Accepts a one-cycle DIV request and latches the operands.
//   - Issues a one-cycle div_start pulse to Div.
//   - Waits for the Div result, or for a divide-by-zero, or for a watchdog timeout.
//   - Owns the architectural HI/LO registers, including MTHI/MTLO writes.
//   - Drives the pipeline stall (busy).
//
// Ports
//   clock, reset        rising-edge clock; asynchronous active-low reset
//   div_req             start a division (sampled only in IDLE)
//   op_a, op_b          dividend / divisor from the register file
//   mthi, mtlo, wdata   architectural HI/LO writes (honoured only in IDLE)
//   finished, div_zero  Div status: result valid / divisor was zero
//   quotient, remainder Div results (committed to LO / HI)
//   div_start           one-cycle start pulse to Div
//   dividend, divisor   latched operands, stable for the whole operation
//   hi, lo              HI / LO registers
//   busy                stall, high whenever not IDLE
//   done                pulse: HI/LO updated with a division result
//   div_zero_exc        pulse: division by zero, HI/LO untouched
//   timeout             pulse: watchdog abort, HI/LO untouched
//
// Every output is taken directly from a flop. There is no combinational
// path from any input to any output.
module hilo_div_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        div_req,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        finished,
  input  logic        div_zero,
  input  logic [31:0] quotient,
  input  logic [31:0] remainder,
  output logic        div_start,
  output logic [31:0] dividend,
  output logic [31:0] divisor,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc,
  output logic        timeout
);

  // One spare bit, so the counter can never wrap before the limit compare.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic [31:0]      dividend_reg, dividend_next;
  logic [31:0]      divisor_reg, divisor_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic             div_start_reg, div_start_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             zero_reg, zero_next;
  logic             timeout_reg, timeout_next;

  // Next-state logic, computed one cycle ahead of the registered outputs.
  // The pulse outputs are registered from here, so each one is high for
  // exactly the cycle that follows the deciding edge.
  always_comb begin
    state_next     = state_reg;
    counter_next   = counter_reg;
    dividend_next  = dividend_reg;
    divisor_next   = divisor_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    div_start_next = 1'b0;
    done_next      = 1'b0;
    zero_next      = 1'b0;
    timeout_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        // Register moves are applied even alongside div_req.
        // The later division result then overwrites them.
        if (mthi) hi_next = wdata;
        if (mtlo) lo_next = wdata;
        if (div_req) begin
          dividend_next  = op_a;
          divisor_next   = op_b;
          div_start_next = 1'b1;   // div_start is high while in START
          state_next     = START;
        end
      end

      START: begin
        counter_next = '0;
        state_next   = WAIT;
      end

      WAIT: begin
        counter_next = counter_reg + CNT_W'(1);
        // div_zero has priority over finished. A zero divisor never commits a result.
        if (div_zero) begin
          zero_next  = 1'b1;
          state_next = IDLE;
        end else if (finished) begin
          hi_next    = remainder;
          lo_next    = quotient;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (counter_reg == CNT_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      counter_reg   <= '0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      div_start_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      zero_reg      <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      counter_reg   <= counter_next;
      dividend_reg  <= dividend_next;
      divisor_reg   <= divisor_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      div_start_reg <= div_start_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      zero_reg      <= zero_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign div_start    = div_start_reg;
  assign dividend     = dividend_reg;
  assign divisor      = divisor_reg;
  assign hi           = hi_reg;
  assign lo           = lo_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign div_zero_exc = zero_reg;
  assign timeout      = timeout_reg;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed testbench for hilo_div_ctrl.
// The Div unit is played by the bench itself, using hand-computed quotient
// and remainder values. The watchdog limit is shortened to 8 cycles.
module tb_hilo_div_ctrl;

  logic        clock;
  logic        reset;
  logic        div_req;
  logic [31:0] op_a, op_b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        finished, div_zero;
  logic [31:0] quotient, remainder;
  logic        div_start;
  logic [31:0] dividend, divisor, hi, lo;
  logic        busy, done, div_zero_exc, timeout;

  int checks = 0;
  int errors = 0;

  hilo_div_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .div_req      (div_req),
    .op_a         (op_a),
    .op_b         (op_b),
    .mthi         (mthi),
    .mtlo         (mtlo),
    .wdata        (wdata),
    .finished     (finished),
    .div_zero     (div_zero),
    .quotient     (quotient),
    .remainder    (remainder),
    .div_start    (div_start),
    .dividend     (dividend),
    .divisor      (divisor),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .done         (done),
    .div_zero_exc (div_zero_exc),
    .timeout      (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete division.
  //   1. Pulse div_req.
  //   2. Hold the Div response off for lat WAIT cycles.
  //   3. Present the Div response and check the result.
  // The next call starts at the very next edge, which is the minimum gap.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic ff, input logic fz,
                        input logic [31:0] q, input logic [31:0] r,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input logic exp_done, input logic exp_exc);
    op_a = a; op_b = b; div_req = 1'b1;
    tick();
    div_req = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("exc_one_cycle", div_zero_exc, 0);
    chk("start_high", div_start, 1);
    chk("busy_start", busy, 1);
    chk("dividend", dividend, a);
    chk("divisor", divisor, b);
    tick();
    chk("start_one_cycle", div_start, 0);
    chk("busy_wait", busy, 1);
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("busy_lat", busy, 1);
      chk("no_early_done", done, 0);
    end
    finished = ff; div_zero = fz; quotient = q; remainder = r;
    tick();
    finished = 1'b0; div_zero = 1'b0;
    chk("done", done, exp_done);
    chk("div_zero_exc", div_zero_exc, exp_exc);
    chk("hi", hi, exp_hi);
    chk("lo", lo, exp_lo);
    chk("busy_end", busy, 0);
    $display("div a=%h b=%h -> hi=%h lo=%h done=%0b exc=%0b", a, b, hi, lo, done, div_zero_exc);
  endtask

  initial begin
    reset = 1'b0; div_req = 1'b0; op_a = '0; op_b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    finished = 1'b0; div_zero = 1'b0; quotient = '0; remainder = '0;

    // Reset state.
    tick(); tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dividend", dividend, 0);
    chk("rst_divisor", divisor, 0);
    chk("rst_flags", {27'd0, div_start, busy, done, div_zero_exc, timeout}, 0);
    $display("reset state checked");
    reset = 1'b1;
    tick();

    // Signed divisions, run back to back.
    do_div(32'd7, 32'd2, 2, 1, 0, 32'd3, 32'd1, 32'd1, 32'd3, 1, 0);
    do_div(32'd15, 32'hFFFF_FFFC, 0, 1, 0, 32'hFFFF_FFFD, 32'd3, 32'd3, 32'hFFFF_FFFD, 1, 0);
    do_div(32'hFFFF_FFF6, 32'd3, 1, 1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1, 0);
    do_div(32'hFFFF_FFF4, 32'hFFFF_FFFC, 3, 1, 0, 32'd3, 32'd0, 32'd0, 32'd3, 1, 0);
    chk("done_last_pulse", done, 1);
    tick();
    chk("done_cleared", done, 0);

    // MTHI and MTLO in the same cycle, then MTLO alone.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_ABCD;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both_hi", hi, 32'h0000_ABCD);
    chk("mt_both_lo", lo, 32'h0000_ABCD);
    mtlo = 1'b1; wdata = 32'h0000_1234;
    tick();
    mtlo = 1'b0;
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_hi_kept", hi, 32'h0000_ABCD);
    $display("mthi/mtlo hi=%h lo=%h", hi, lo);

    // 1 / 0: exception, HI/LO untouched. Then 5 / 70.
    do_div(32'd1, 32'd0, 1, 0, 1, 32'hDEAD_0001, 32'hDEAD_0002,
           32'h0000_ABCD, 32'h0000_1234, 0, 1);
    do_div(32'd5, 32'd70, 1, 1, 0, 32'd0, 32'd5, 32'd5, 32'd0, 1, 0);
    tick();

    // Watchdog: Div never answers. An MTHI attempted while busy must be ignored.
    op_a = 32'd9; op_b = 32'd9; div_req = 1'b1;
    tick();
    div_req = 1'b0;
    tick();                      // WAIT entry edge
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin mthi = 1'b1; wdata = 32'h0000_DEAD; end
      tick();
      mthi = 1'b0;
      if (i == 7) begin
        chk("timeout_early", timeout, 0);
        chk("busy_before_to", busy, 1);
      end
    end
    chk("timeout", timeout, 1);
    chk("busy_after_to", busy, 0);
    chk("hi_after_to", hi, 32'd5);
    chk("lo_after_to", lo, 32'd0);
    chk("done_after_to", done, 0);
    tick();
    chk("timeout_one_cycle", timeout, 0);
    $display("timeout hi=%h lo=%h", hi, lo);

    // div_zero and finished in the same cycle: div_zero wins, no write.
    do_div(32'd8, 32'd0, 0, 1, 1, 32'h0000_0099, 32'h0000_0077, 32'd5, 32'd0, 0, 1);
    tick();

    // MTHI in the same cycle as div_req: applied, then overwritten by the result.
    mthi = 1'b1; wdata = 32'h0000_0055; op_a = 32'd9; op_b = 32'd4; div_req = 1'b1;
    tick();
    mthi = 1'b0; div_req = 1'b0;
    chk("mthi_with_req", hi, 32'h0000_0055);
    tick();
    finished = 1'b1; quotient = 32'd2; remainder = 32'd1;
    tick();
    finished = 1'b0;
    chk("overwrite_hi", hi, 32'd1);
    chk("overwrite_lo", lo, 32'd2);
    chk("overwrite_done", done, 1);
    $display("mthi+div hi=%h lo=%h", hi, lo);
    tick();

    // Asynchronous reset during WAIT. A late finished is then ignored.
    op_a = 32'd100; op_b = 32'd7; div_req = 1'b1;
    tick();
    div_req = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_start", div_start, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_dividend", dividend, 0);
    tick();
    reset = 1'b1;
    finished = 1'b1; quotient = 32'h0000_0042; remainder = 32'h0000_0043;
    tick();
    finished = 1'b0;
    chk("late_fin_done", done, 0);
    chk("late_fin_hi", hi, 0);
    chk("late_fin_lo", lo, 0);
    chk("late_fin_busy", busy, 0);
    $display("async reset mid-op hi=%h lo=%h", hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
